// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard control unit and its forwarding logic.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } hz_state_e;

  localparam int WAIT_CNT_W = 8;
  localparam int REG_AW_MAX = 8;

  // Register-address equality; register 0 never matches when it is hardwired.
  function automatic logic reg_match(input logic [REG_AW_MAX-1:0] a,
                                     input logic [REG_AW_MAX-1:0] d,
                                     input logic r0_hw);
    return (a == d) && !(r0_hw && (d == '0));
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side signals of the hazard control unit: ID/EX/MEM operand info in, pipeline
// enables and status out.
interface hazard_ctrl_unit_if #(parameter int REG_AW = 3);

  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_branch;
  logic              id_br_taken;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_memread;
  // Data-memory handshake: dmem_req marks an access in MEM; it completes in the first cycle
  // dmem_ready is sampled high with dmem_req, and every req-high/ready-low cycle freezes the pipe.
  logic              dmem_req;
  logic              dmem_ready;

  logic              pc_write;
  logic              id_write;
  logic              ctrl_flush;
  logic              if_flush;
  logic              ex_mem_hold;
  logic              mem_timeout;
  logic [1:0]        hz_state;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch, id_br_taken,
           ex_rd, ex_regwrite, ex_memread, mem_rd, mem_memread, dmem_req, dmem_ready,
    input  pc_write, id_write, ctrl_flush, if_flush, ex_mem_hold, mem_timeout, hz_state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch, id_br_taken,
           ex_rd, ex_regwrite, ex_memread, mem_rd, mem_memread, dmem_req, dmem_ready,
    output pc_write, id_write, ctrl_flush, if_flush, ex_mem_hold, mem_timeout, hz_state
  );

endinterface

// File: rtl/hazard_mem_wait_fsm.sv
// Data-memory wait tracker: counts consecutive not-ready cycles and latches a sticky
// timeout once MEM_WAIT_MAX is exceeded.
module hazard_mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       freeze_active,
  output logic       timeout,
  output logic       mem_timeout,
  output logic [1:0] state
);

  localparam logic [1:0] S_RUN      = RUN;
  localparam logic [1:0] S_MEM_WAIT = MEM_WAIT;
  localparam logic [1:0] S_TIMEOUT  = TIMEOUT;
  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = WAIT_CNT_W'(MEM_WAIT_MAX);

  logic [WAIT_CNT_W-1:0] wait_cnt;

  assign freeze_active = dmem_req && !dmem_ready;
  assign timeout       = (state == S_TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (freeze_active) begin
            state    <= S_MEM_WAIT;
            wait_cnt <= WAIT_CNT_W'(1);
          end
        end
        S_MEM_WAIT: begin
          // Ready in the final allowed cycle still completes the access.
          if (!freeze_active) begin
            state    <= S_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_MAX) begin
            state       <= S_TIMEOUT;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
          end
        end
        S_TIMEOUT: ;
        default: begin
          state    <= S_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ID-stage hazard control: load-use / branch-operand stalls, taken-branch squash and memory
// freeze. Optional saturating perf counters are enabled with HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW       = 3,
  parameter int R0_HARDWIRED = 1,
  parameter int MEM_WAIT_MAX = 15,
  parameter int STALL_CNT_W  = 16
) (
  input  logic clk,
  input  logic rst,
  hazard_ctrl_unit_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] bubble_cnt,
  output logic [STALL_CNT_W-1:0] freeze_cnt,
  output logic [STALL_CNT_W-1:0] flush_cnt
`endif
);

  localparam logic R0_HW = (R0_HARDWIRED != 0);

  logic [REG_AW_MAX-1:0] rs, rt, ex_rd, mem_rd;
  logic src_ex, src_mem;
  logic load_use, br_ex, br_mem, bubble;
  logic freeze_active, timeout;
  logic pc_write, id_write, ctrl_flush, if_flush, ex_mem_hold;

  assign rs     = REG_AW_MAX'(bus.id_rs[REG_AW-1:0]);
  assign rt     = REG_AW_MAX'(bus.id_rt[REG_AW-1:0]);
  assign ex_rd  = REG_AW_MAX'(bus.ex_rd[REG_AW-1:0]);
  assign mem_rd = REG_AW_MAX'(bus.mem_rd[REG_AW-1:0]);

  assign src_ex  = (bus.id_uses_rs && reg_match(rs, ex_rd, R0_HW)) ||
                   (bus.id_uses_rt && reg_match(rt, ex_rd, R0_HW));
  assign src_mem = (bus.id_uses_rs && reg_match(rs, mem_rd, R0_HW)) ||
                   (bus.id_uses_rt && reg_match(rt, mem_rd, R0_HW));

  // A load feeding a branch stalls twice: once in EX (br_ex) and again in MEM (br_mem).
  assign load_use = bus.ex_memread && src_ex;
  assign br_ex    = bus.id_branch && bus.ex_regwrite && src_ex;
  assign br_mem   = bus.id_branch && bus.mem_memread && src_mem;
  assign bubble   = load_use || br_ex || br_mem;

  hazard_mem_wait_fsm #(
    .MEM_WAIT_MAX (MEM_WAIT_MAX)
  ) u_mem_wait (
    .clk           (clk),
    .rst           (rst),
    .dmem_req      (bus.dmem_req),
    .dmem_ready    (bus.dmem_ready),
    .freeze_active (freeze_active),
    .timeout       (timeout),
    .mem_timeout   (bus.mem_timeout),
    .state         (bus.hz_state)
  );

  always_comb begin
    pc_write    = 1'b1;
    id_write    = 1'b1;
    ctrl_flush  = 1'b0;
    if_flush    = 1'b0;
    ex_mem_hold = 1'b0;
    if (rst) begin
      pc_write   = 1'b0;
      id_write   = 1'b0;
      ctrl_flush = 1'b1;
      if_flush   = 1'b1;
    end else if (timeout || freeze_active) begin
      pc_write    = 1'b0;
      id_write    = 1'b0;
      ex_mem_hold = 1'b1;
    end else if (bubble) begin
      pc_write   = 1'b0;
      id_write   = 1'b0;
      ctrl_flush = 1'b1;
    end else if (bus.id_branch && bus.id_br_taken) begin
      if_flush = 1'b1;
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.id_write    = id_write;
  assign bus.ctrl_flush  = ctrl_flush;
  assign bus.if_flush    = if_flush;
  assign bus.ex_mem_hold = ex_mem_hold;

`ifdef HAZARD_PERF_CNT_EN
  logic sel_freeze, sel_bubble, sel_flush;

  assign sel_freeze = timeout || freeze_active;
  assign sel_bubble = !sel_freeze && bubble;
  assign sel_flush  = !sel_freeze && !bubble && bus.id_branch && bus.id_br_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      freeze_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (sel_bubble && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + STALL_CNT_W'(1);
      if (sel_freeze && (freeze_cnt != '1)) freeze_cnt <= freeze_cnt + STALL_CNT_W'(1);
      if (sel_flush  && (flush_cnt  != '1)) flush_cnt  <= flush_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenario tables plus randomized traffic,
// all checked against a rule-level reference model.
module tb_hazard_ctrl_unit;

  localparam int REG_AW = 3;
  localparam int R0_HW  = 1;
  localparam int MAXW   = 4;
  localparam int SCW    = 4;
  localparam int CMAX   = (1 << SCW) - 1;

  // Field order: rst, rs, rt, urs, urt, br, tk, exrd, exw, exl, memrd, meml, req, rdy,
  // then expected {pc_write,id_write,ctrl_flush,if_flush,ex_mem_hold}, hz_state, mem_timeout.
  typedef struct {
    bit rst; int rs; int rt; bit urs; bit urt; bit br; bit tk;
    int exrd; bit exw; bit exl; int memrd; bit meml; bit req; bit rdy;
    logic [4:0] ctl; logic [1:0] st; logic to;
  } step_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  // Reference model state: length of the current not-ready run, sticky timeout, counters.
  int m_frz_run = 0;
  bit m_to      = 1'b0;
  int m_bub = 0, m_frz = 0, m_fl = 0;

  hazard_ctrl_unit_if #(.REG_AW(REG_AW)) bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [SCW-1:0] bubble_cnt, freeze_cnt, flush_cnt;
`endif

  hazard_ctrl_unit #(
    .REG_AW       (REG_AW),
    .R0_HARDWIRED (R0_HW),
    .MEM_WAIT_MAX (MAXW),
    .STALL_CNT_W  (SCW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .bubble_cnt (bubble_cnt),
    .freeze_cnt (freeze_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit hits(int src, int dst);
    return (src == dst) && !((R0_HW != 0) && (dst == 0));
  endfunction

  // 0 reset, 1 frozen (wait or timeout), 2 bubble, 3 taken-branch flush, 4 normal.
  function automatic int rule_of();
    bit sex, smem, bub;
    sex  = (bus.id_uses_rs && hits(int'(bus.id_rs), int'(bus.ex_rd))) ||
           (bus.id_uses_rt && hits(int'(bus.id_rt), int'(bus.ex_rd)));
    smem = (bus.id_uses_rs && hits(int'(bus.id_rs), int'(bus.mem_rd))) ||
           (bus.id_uses_rt && hits(int'(bus.id_rt), int'(bus.mem_rd)));
    bub  = (bus.ex_memread && sex) || (bus.id_branch && bus.ex_regwrite && sex) ||
           (bus.id_branch && bus.mem_memread && smem);
    if (rst) return 0;
    if (m_to || (bus.dmem_req && !bus.dmem_ready)) return 1;
    if (bub) return 2;
    if (bus.id_branch && bus.id_br_taken) return 3;
    return 4;
  endfunction

  function automatic logic [7:0] model_out();
    logic [4:0] ctl;
    logic [1:0] st;
    case (rule_of())
      0: ctl = 5'b00110;
      1: ctl = 5'b00001;
      2: ctl = 5'b00100;
      3: ctl = 5'b11010;
      default: ctl = 5'b11000;
    endcase
    st = m_to ? 2'd2 : ((m_frz_run > 0) ? 2'd1 : 2'd0);
    return {ctl, m_to, st};
  endfunction

  function automatic logic [7:0] get_obs();
    return {bus.pc_write, bus.id_write, bus.ctrl_flush, bus.if_flush, bus.ex_mem_hold,
            bus.mem_timeout, bus.hz_state};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input step_t s);
    rst             = s.rst;
    bus.id_rs       = REG_AW'(s.rs);
    bus.id_rt       = REG_AW'(s.rt);
    bus.id_uses_rs  = s.urs;
    bus.id_uses_rt  = s.urt;
    bus.id_branch   = s.br;
    bus.id_br_taken = s.tk;
    bus.ex_rd       = REG_AW'(s.exrd);
    bus.ex_regwrite = s.exw;
    bus.ex_memread  = s.exl;
    bus.mem_rd      = REG_AW'(s.memrd);
    bus.mem_memread = s.meml;
    bus.dmem_req    = s.req;
    bus.dmem_ready  = s.rdy;
  endtask

  task automatic advance();
    int r;
    @(posedge clk);
    r = rule_of();
    if (rst) begin
      m_frz_run = 0; m_to = 1'b0; m_bub = 0; m_frz = 0; m_fl = 0;
    end else begin
      if (r == 1 && m_frz < CMAX) m_frz++;
      if (r == 2 && m_bub < CMAX) m_bub++;
      if (r == 3 && m_fl  < CMAX) m_fl++;
      if (!m_to) begin
        if (bus.dmem_req && !bus.dmem_ready) begin
          m_frz_run++;
          if (m_frz_run == MAXW + 1) m_to = 1'b1;
        end else begin
          m_frz_run = 0;
        end
      end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step_t seq [2];
    logic [7:0] exp, obs;
    seq[0] = '{1, 0,0,0,0,0,0, 0,0,0, 0,0, 0,0, 5'b00110, 2'd0, 1'b0};
    seq[1] = '{0, 0,0,0,0,0,0, 0,0,0, 0,0, 0,0, 5'b11000, 2'd0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      apply(seq[i]);
      @(negedge clk);
      exp = model_out(); obs = get_obs();
      total++;
      if (obs !== exp) begin bad++; $display("FAIL reset[%0d] model: got %b want %b", i, obs, exp); end
      total++;
      if (obs !== {seq[i].ctl, seq[i].to, seq[i].st}) begin
        bad++; $display("FAIL reset[%0d] table: got %b want %b", i, obs, {seq[i].ctl, seq[i].to, seq[i].st});
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    step_t seq [5];
    logic [7:0] exp, obs;
    seq[0] = '{0, 3,0,1,0,0,0, 3,1,1, 0,0, 0,0, 5'b00100, 2'd0, 1'b0};
    seq[1] = '{0, 3,0,1,0,0,0, 0,0,0, 3,1, 0,0, 5'b11000, 2'd0, 1'b0};
    seq[2] = '{0, 0,0,1,0,0,0, 0,1,1, 0,0, 0,0, 5'b11000, 2'd0, 1'b0};
    seq[3] = '{0, 0,3,0,0,0,0, 3,1,1, 0,0, 0,0, 5'b11000, 2'd0, 1'b0};
    seq[4] = '{0, 0,3,0,1,0,0, 3,1,1, 0,0, 0,0, 5'b00100, 2'd0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      apply(seq[i]);
      @(negedge clk);
      exp = model_out(); obs = get_obs();
      total++;
      if (obs !== exp) begin bad++; $display("FAIL load_use[%0d] model: got %b want %b", i, obs, exp); end
      total++;
      if (obs !== {seq[i].ctl, seq[i].to, seq[i].st}) begin
        bad++; $display("FAIL load_use[%0d] table: got %b want %b", i, obs, {seq[i].ctl, seq[i].to, seq[i].st});
      end
      advance();
    end
  endtask

  task automatic test_branch_hazard();
    step_t seq [7];
    logic [7:0] exp, obs;
    seq[0] = '{0, 0,5,0,1,1,1, 5,1,1, 0,0, 0,0, 5'b00100, 2'd0, 1'b0};
    seq[1] = '{0, 0,5,0,1,1,1, 0,0,0, 5,1, 0,0, 5'b00100, 2'd0, 1'b0};
    seq[2] = '{0, 0,5,0,1,1,1, 0,0,0, 0,0, 0,0, 5'b11010, 2'd0, 1'b0};
    seq[3] = '{0, 0,0,0,0,0,0, 0,0,0, 0,0, 0,0, 5'b11000, 2'd0, 1'b0};
    seq[4] = '{0, 0,5,0,1,1,1, 5,1,0, 0,0, 0,0, 5'b00100, 2'd0, 1'b0};
    seq[5] = '{0, 0,5,0,1,1,1, 0,0,0, 5,0, 0,0, 5'b11010, 2'd0, 1'b0};
    seq[6] = '{0, 0,5,0,1,1,0, 0,0,0, 0,0, 0,0, 5'b11000, 2'd0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      apply(seq[i]);
      @(negedge clk);
      exp = model_out(); obs = get_obs();
      total++;
      if (obs !== exp) begin bad++; $display("FAIL branch[%0d] model: got %b want %b", i, obs, exp); end
      total++;
      if (obs !== {seq[i].ctl, seq[i].to, seq[i].st}) begin
        bad++; $display("FAIL branch[%0d] table: got %b want %b", i, obs, {seq[i].ctl, seq[i].to, seq[i].st});
      end
      advance();
    end
  endtask

  task automatic test_mem_wait();
    step_t seq [11];
    logic [7:0] exp, obs;
    // Three not-ready cycles with a pending load-use, then release.
    seq[0]  = '{0, 3,0,1,0,0,0, 3,1,1, 0,0, 1,0, 5'b00001, 2'd0, 1'b0};
    seq[1]  = '{0, 3,0,1,0,0,0, 3,1,1, 0,0, 1,0, 5'b00001, 2'd1, 1'b0};
    seq[2]  = '{0, 3,0,1,0,0,0, 3,1,1, 0,0, 1,0, 5'b00001, 2'd1, 1'b0};
    seq[3]  = '{0, 3,0,1,0,0,0, 3,1,1, 0,0, 1,1, 5'b00100, 2'd1, 1'b0};
    seq[4]  = '{0, 0,0,0,0,0,0, 0,0,0, 0,0, 0,0, 5'b11000, 2'd0, 1'b0};
    // Ready arrives exactly when the wait count reaches its limit.
    seq[5]  = '{0, 0,0,0,0,0,0, 0,0,0, 0,0, 1,0, 5'b00001, 2'd0, 1'b0};
    seq[6]  = '{0, 0,0,0,0,0,0, 0,0,0, 0,0, 1,0, 5'b00001, 2'd1, 1'b0};
    seq[7]  = '{0, 0,0,0,0,0,0, 0,0,0, 0,0, 1,0, 5'b00001, 2'd1, 1'b0};
    seq[8]  = '{0, 0,0,0,0,0,0, 0,0,0, 0,0, 1,0, 5'b00001, 2'd1, 1'b0};
    seq[9]  = '{0, 0,0,0,0,0,0, 0,0,0, 0,0, 1,1, 5'b11000, 2'd1, 1'b0};
    seq[10] = '{0, 0,0,0,0,0,0, 0,0,0, 0,0, 0,0, 5'b11000, 2'd0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      apply(seq[i]);
      @(negedge clk);
      exp = model_out(); obs = get_obs();
      total++;
      if (obs !== exp) begin bad++; $display("FAIL mem_wait[%0d] model: got %b want %b", i, obs, exp); end
      total++;
      if (obs !== {seq[i].ctl, seq[i].to, seq[i].st}) begin
        bad++; $display("FAIL mem_wait[%0d] table: got %b want %b", i, obs, {seq[i].ctl, seq[i].to, seq[i].st});
      end
      advance();
    end
  endtask

  task automatic test_timeout();
    step_t seq [13];
    logic [7:0] exp, obs;
    for (int i = 0; i < 5; i++)
      seq[i] = '{0, 0,0,0,0,0,0, 0,0,0, 0,0, 1,0, 5'b00001, (i == 0) ? 2'd0 : 2'd1, 1'b0};
    seq[5]  = '{0, 0,0,0,0,0,0, 0,0,0, 0,0, 0,0, 5'b00001, 2'd2, 1'b1};
    seq[6]  = '{0, 0,0,0,0,1,1, 0,0,0, 0,0, 1,1, 5'b00001, 2'd2, 1'b1};
    seq[7]  = '{1, 0,0,0,0,0,0, 0,0,0, 0,0, 0,0, 5'b00110, 2'd2, 1'b1};
    seq[8]  = '{0, 0,0,0,0,0,0, 0,0,0, 0,0, 0,0, 5'b11000, 2'd0, 1'b0};
    // Reset in the middle of a wait abandons the access.
    seq[9]  = '{0, 0,0,0,0,0,0, 0,0,0, 0,0, 1,0, 5'b00001, 2'd0, 1'b0};
    seq[10] = '{0, 0,0,0,0,0,0, 0,0,0, 0,0, 1,0, 5'b00001, 2'd1, 1'b0};
    seq[11] = '{1, 0,0,0,0,0,0, 0,0,0, 0,0, 1,0, 5'b00110, 2'd1, 1'b0};
    seq[12] = '{0, 0,0,0,0,0,0, 0,0,0, 0,0, 0,0, 5'b11000, 2'd0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      apply(seq[i]);
      @(negedge clk);
      exp = model_out(); obs = get_obs();
      total++;
      if (obs !== exp) begin bad++; $display("FAIL timeout[%0d] model: got %b want %b", i, obs, exp); end
      total++;
      if (obs !== {seq[i].ctl, seq[i].to, seq[i].st}) begin
        bad++; $display("FAIL timeout[%0d] table: got %b want %b", i, obs, {seq[i].ctl, seq[i].to, seq[i].st});
      end
      advance();
    end
  endtask

  task automatic test_random();
    step_t s;
    logic [7:0] exp, obs;
    for (int i = 0; i < 400; i++) begin
      s = '{($urandom_range(0, 39) == 0),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            int'($urandom_range(0, 7)), $urandom_range(0, 1), $urandom_range(0, 1),
            int'($urandom_range(0, 7)), $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
            5'b0, 2'd0, 1'b0};
      apply(s);
      @(negedge clk);
      exp = model_out(); obs = get_obs();
      total++;
      if (obs !== exp) begin bad++; $display("FAIL random[%0d]: got %b want %b", i, obs, exp); end
`ifdef HAZARD_PERF_CNT_EN
      total++;
      if ({bubble_cnt, freeze_cnt, flush_cnt} !== {SCW'(m_bub), SCW'(m_frz), SCW'(m_fl)}) begin
        bad++;
        $display("FAIL random_cnt[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                 bubble_cnt, freeze_cnt, flush_cnt, m_bub, m_frz, m_fl);
      end
`endif
      advance();
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_counter_saturation();
    step_t rs_step, lu_step;
    rs_step = '{1, 0,0,0,0,0,0, 0,0,0, 0,0, 0,0, 5'b0, 2'd0, 1'b0};
    lu_step = '{0, 3,0,1,0,0,0, 3,1,1, 0,0, 0,0, 5'b0, 2'd0, 1'b0};
    apply(rs_step); advance();
    for (int i = 0; i < 20; i++) begin
      apply(lu_step);
      @(negedge clk);
      total++;
      if (bubble_cnt !== SCW'(m_bub)) begin
        bad++; $display("FAIL sat_bubble[%0d]: got %0d want %0d", i, bubble_cnt, m_bub);
      end
      advance();
    end
    total++;
    if (bubble_cnt !== 4'd15) begin bad++; $display("FAIL sat_final: got %0d want 15", bubble_cnt); end
    apply(rs_step); advance();
    total++;
    if (bubble_cnt !== 4'd0) begin bad++; $display("FAIL sat_clear: got %0d want 0", bubble_cnt); end
  endtask
`endif

  initial begin
    step_t idle;
    idle = '{1, 0,0,0,0,0,0, 0,0,0, 0,0, 0,0, 5'b0, 2'd0, 1'b0};
    apply(idle);
    advance();
    advance();
    test_reset();
    test_load_use();
    test_branch_hazard();
    test_mem_wait();
    test_timeout();
    test_random();
`ifdef HAZARD_PERF_CNT_EN
    test_counter_saturation();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
